// File: rtl/mw_load_store_unit.sv
// MW-stage load/store unit: issues one bus access per memory op over a req/gnt/rvalid
// bus, stalls the MW register until it completes, and returns extended load data.
// Optional misaligned-access trap: define MW_MISALIGN_TRAP_EN.
module mw_load_store_unit #(
    parameter int BUS_ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           ALUResult_MW,
    input  logic [31:0]           rdata2_MW,
    input  logic [2:0]            funct3_MW,
    input  logic                  mem_rd_MW,
    input  logic                  mem_wr_MW,
    output logic                  Stall_MW,
    output logic [31:0]           load_data_MW,
    output logic                  load_valid_MW,
    output logic                  dbus_req,
    output logic                  dbus_we,
    output logic [BUS_ADDR_W-1:0] dbus_addr,
    output logic [31:0]           dbus_wdata,
    output logic [3:0]            dbus_wmask,
    input  logic                  dbus_gnt,
    input  logic                  dbus_rvalid,
    input  logic [31:0]           dbus_rdata,
    output logic                  misaligned_MW
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      r_state;
    logic        r_is_load;
    logic [31:0] r_load_data;

    logic        w_acc;
    logic        w_store;
    logic [1:0]  w_off;
    logic [1:0]  w_size;
    logic        w_misal;
    logic        w_issue;
    logic [3:0]  w_mask;
    logic [31:0] w_wdata;
    logic [31:0] w_bsh;
    logic [31:0] w_hsh;
    logic [31:0] w_load_ext;

    assign w_acc   = mem_rd_MW | mem_wr_MW;
    assign w_store = mem_wr_MW;
    assign w_off   = ALUResult_MW[1:0];
    // funct3[1:0]: 00 byte, 01 half, 10/11 word (reserved 3/6/7 fall into word)
    assign w_size  = funct3_MW[1:0];

`ifdef MW_MISALIGN_TRAP_EN
    always_comb begin
        w_misal = 1'b0;
        case (w_size)
            2'b00:   w_misal = 1'b0;
            2'b01:   w_misal = w_off[0];
            default: w_misal = (w_off != 2'b00);
        endcase
    end
`else
    assign w_misal = 1'b0;
`endif

    // Store lane placement
    always_comb begin
        w_mask  = 4'b1111;
        w_wdata = rdata2_MW;
        case (w_size)
            2'b00: begin
                w_mask  = 4'b0001 << w_off;
                w_wdata = {4{rdata2_MW[7:0]}};
            end
            2'b01: begin
                w_mask  = 4'b0011 << {w_off[1], 1'b0};
                w_wdata = {2{rdata2_MW[15:0]}};
            end
            default: begin
                w_mask  = 4'b1111;
                w_wdata = rdata2_MW;
            end
        endcase
    end

    // Load extraction: shift the addressed lane down, then sign/zero extend
    assign w_bsh = dbus_rdata >> {w_off, 3'b000};
    assign w_hsh = dbus_rdata >> {w_off[1], 4'b0000};

    always_comb begin
        w_load_ext = dbus_rdata;
        case (w_size)
            2'b00:   w_load_ext = {{24{w_bsh[7] & ~funct3_MW[2]}}, w_bsh[7:0]};
            2'b01:   w_load_ext = {{16{w_hsh[15] & ~funct3_MW[2]}}, w_hsh[15:0]};
            default: w_load_ext = dbus_rdata;
        endcase
    end

    assign w_issue = ((r_state == S_IDLE) && w_acc && !w_misal) || (r_state == S_REQ);

    // Outputs are gated by rst so a pending request is dropped in the reset cycle
    assign dbus_req      = w_issue & ~rst;
    assign dbus_we       = dbus_req & w_store;
    assign dbus_wmask    = dbus_we ? w_mask : 4'b0000;
    assign dbus_wdata    = w_wdata;
    assign dbus_addr     = {ALUResult_MW[BUS_ADDR_W-1:2], 2'b00};
    assign Stall_MW      = (w_issue || (r_state == S_WAIT)) & ~rst;
    assign load_valid_MW = (r_state == S_DONE) & r_is_load & ~rst;
    assign misaligned_MW = (r_state == S_IDLE) & w_acc & w_misal & ~rst;
    assign load_data_MW  = r_load_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_is_load   <= 1'b0;
            r_load_data <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc && !w_misal) begin
                        r_is_load <= ~w_store;
                        if (!dbus_gnt)    r_state <= S_REQ;
                        else if (w_store) r_state <= S_DONE;
                        else              r_state <= S_WAIT;
                    end
                end
                S_REQ: begin
                    if (dbus_gnt) r_state <= w_store ? S_DONE : S_WAIT;
                end
                S_WAIT: begin
                    if (dbus_rvalid) begin
                        r_load_data <= w_load_ext;
                        r_state     <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
